// File: rtl/mdio_master_if.sv
// rtl/mdio_master_if.sv - command/response handshake and MDIO pad signals of the MDIO master
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    modport master (
        input  cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata, mdio_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata, mdio_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe
    );
endinterface

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - clause-22 MDIO management master serialising single register commands
module mdio_master #(
    parameter int DIV_HALF = 25,
    parameter bit PRE_EN   = 1'b1
) (
    input  logic          clk125m,
    input  logic          rst,
    mdio_master_if.master bus
);

    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

    typedef enum logic [3:0] {
        IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] div_cnt;
    logic          mdc_q;
    logic [4:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [15:0]   rx_sr;
    logic          wr_q;
    logic          ta_err;
    logic          ready_q;
    logic [15:0]   rdata_q;
    logic          err_q;
    logic          mdio_meta;
    logic          mdio_s;

    logic busy;
    logic bit_end;
    logic rise_cycle;
    logic accept;

    // Index of the last bit of each field; bit_cnt counts down to zero.
    function automatic logic [4:0] field_last(input state_t s);
        case (s)
            PRE:          field_last = 5'd31;
            PHYAD, REGAD: field_last = 5'd4;
            DATA:         field_last = 5'd15;
            default:      field_last = 5'd1;
        endcase
    endfunction

    assign busy       = (state != IDLE) && (state != DONE);
    assign bit_end    = busy && mdc_q && (div_cnt == '0);
    // First cycle of the MDC high phase; the PHY has had the whole low phase to settle.
    assign rise_cycle = busy && mdc_q && (div_cnt == DIV_LAST);
    assign accept     = bus.cmd_valid && ready_q;

    always_ff @(posedge clk125m) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PRE_EN ? PRE : ST;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                if (bit_end && (bit_cnt == 5'd0)) begin
                    case (state)
                        PRE:     state_next = ST;
                        ST:      state_next = OP;
                        OP:      state_next = PHYAD;
                        PHYAD:   state_next = REGAD;
                        REGAD:   state_next = TA;
                        TA:      state_next = DATA;
                        default: state_next = DONE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready = ready_q;
        bus.rsp_valid = (state == DONE);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        bus.mdc       = mdc_q;
        bus.mdio_oe   = 1'b0;
        bus.mdio_o    = 1'b1;
        case (state)
            PRE: begin
                bus.mdio_oe = 1'b1;
            end
            ST, OP, PHYAD, REGAD: begin
                bus.mdio_oe = 1'b1;
                bus.mdio_o  = tx_sr[31];
            end
            TA, DATA: begin
                // Reads release the line for turnaround and data.
                if (wr_q) begin
                    bus.mdio_oe = 1'b1;
                    bus.mdio_o  = tx_sr[31];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk125m) begin
        if (rst) begin
            div_cnt   <= '0;
            mdc_q     <= 1'b0;
            bit_cnt   <= 5'd0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            wr_q      <= 1'b0;
            ta_err    <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mdio_meta <= 1'b1;
            mdio_s    <= 1'b1;
        end else begin
            mdio_meta <= bus.mdio_i;
            mdio_s    <= mdio_meta;
            ready_q   <= (state_next == IDLE);

            if (state != state_next) begin
                bit_cnt <= field_last(state_next);
            end else if (bit_end) begin
                bit_cnt <= bit_cnt - 5'd1;
            end

            if (accept) begin
                wr_q    <= bus.cmd_write;
                // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA.
                tx_sr   <= {2'b01, (bus.cmd_write ? 2'b01 : 2'b10), bus.cmd_phyad,
                            bus.cmd_regad, 2'b10, bus.cmd_wdata};
                div_cnt <= DIV_LAST;
                mdc_q   <= 1'b0;
            end else if (busy) begin
                if (div_cnt == '0) begin
                    div_cnt <= DIV_LAST;
                    mdc_q   <= ~mdc_q;
                end else begin
                    div_cnt <= div_cnt - DW'(1);
                end
                if (bit_end && (state != PRE)) begin
                    tx_sr <= {tx_sr[30:0], 1'b0};
                end
            end else begin
                mdc_q <= 1'b0;
            end

            if (rise_cycle && !wr_q) begin
                if ((state == TA) && (bit_cnt == 5'd0)) begin
                    ta_err <= mdio_s;
                end
                if (state == DATA) begin
                    rx_sr <= {rx_sr[14:0], mdio_s};
                end
            end

            if (bit_end && (state_next == DONE)) begin
                if (wr_q) begin
                    err_q <= 1'b0;
                end else begin
                    rdata_q <= rx_sr;
                    err_q   <= ta_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - randomized self-checking bench for mdio_master with a behavioural PHY
module tb_mdio_master;

    localparam int DH = 4;

    typedef struct {
        int        cyc;
        bit        wr;
        bit [4:0]  pa;
        bit [4:0]  ra;
        bit [15:0] wd;
    } acc_t;

    typedef struct {
        int        cyc;
        bit [15:0] rd;
        bit        err;
        int        nbits;
        bit [63:0] fo;
        bit [63:0] foe;
    } rsp_t;

    logic clk125m = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #4 clk125m = ~clk125m;
    always @(posedge clk125m) cyc <= cyc + 1;

    logic [1:0]  drv_valid;
    logic [1:0]  drv_write;
    logic [4:0]  drv_phy [2];
    logic [4:0]  drv_reg [2];
    logic [15:0] drv_wd [2];
    logic [1:0]  phy_drv = 2'b11;

    logic [1:0]  m_ready, m_rv, m_err, m_mdc, m_o, m_oe;
    logic [15:0] m_rd [2];

    mdio_master_if ifs[2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ifs[g].cmd_valid = drv_valid[g];
        assign ifs[g].cmd_write = drv_write[g];
        assign ifs[g].cmd_phyad = drv_phy[g];
        assign ifs[g].cmd_regad = drv_reg[g];
        assign ifs[g].cmd_wdata = drv_wd[g];
        assign ifs[g].mdio_i    = phy_drv[g];
        assign m_ready[g] = ifs[g].cmd_ready;
        assign m_rv[g]    = ifs[g].rsp_valid;
        assign m_err[g]   = ifs[g].rsp_err;
        assign m_mdc[g]   = ifs[g].mdc;
        assign m_o[g]     = ifs[g].mdio_o;
        assign m_oe[g]    = ifs[g].mdio_oe;
        assign m_rd[g]    = ifs[g].rsp_rdata;

        mdio_master #(.DIV_HALF(DH), .PRE_EN(g == 0)) dut (
            .clk125m (clk125m),
            .rst     (rst),
            .bus     (ifs[g])
        );
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          dbl_rsp = 0;
    logic [15:0] phy_regs [2][3][32];
    logic [15:0] model_regs [2][3][32];
    logic [15:0] last_rd [2];
    acc_t        acc_q [2][$];
    rsp_t        rsp_q [2][$];
    logic [63:0] fo [2];
    logic [63:0] foe [2];
    int          nb [2];
    bit [1:0]    prev_mdc;
    bit [1:0]    prev_rv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int field_val(input int g, input int pos, input int len);
        int v = 0;
        for (int k = 0; k < len; k++) v = v * 2 + int'(fo[g][pos + k]);
        return v;
    endfunction

    // PHY model: answers reads to phy0..2 after a valid header; everything else sees the pull-up.
    function automatic bit phy_bit(input int g);
        int off = (g == 0) ? 32 : 0;
        int idx = nb[g] - off;
        int pa, ra;
        if (idx < 14 || idx > 31) return 1'b1;
        if (field_val(g, off, 4) != 4'b0110) return 1'b1;
        pa = field_val(g, off + 4, 5);
        ra = field_val(g, off + 9, 5);
        if (pa > 2 || idx == 14) return 1'b1;
        if (idx == 15) return 1'b0;
        return phy_regs[g][pa][ra][31 - idx];
    endfunction

    function automatic void phy_write(input int g);
        int off = (g == 0) ? 32 : 0;
        int pa, ra;
        if (nb[g] != off + 32 || field_val(g, off, 4) != 4'b0101) return;
        pa = field_val(g, off + 4, 5);
        ra = field_val(g, off + 9, 5);
        if (pa <= 2) phy_regs[g][pa][ra] = 16'(field_val(g, off + 16, 16));
    endfunction

    always @(negedge clk125m) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                nb[g] = 0; fo[g] = '0; foe[g] = '0;
                prev_mdc[g] = 1'b0; prev_rv[g] = 1'b0; phy_drv[g] = 1'b1;
            end else begin
                if (drv_valid[g] && m_ready[g]) begin
                    acc_q[g].push_back('{cyc, drv_write[g], drv_phy[g], drv_reg[g], drv_wd[g]});
                    nb[g] = 0; fo[g] = '0; foe[g] = '0;
                end
                if (m_mdc[g] && !prev_mdc[g]) begin
                    if (nb[g] < 64) begin
                        fo[g][nb[g]]  = m_o[g];
                        foe[g][nb[g]] = m_oe[g];
                    end
                    nb[g]++;
                end
                if (!m_mdc[g] && prev_mdc[g]) phy_drv[g] = phy_bit(g);
                if (m_rv[g]) begin
                    if (prev_rv[g]) dbl_rsp++;
                    rsp_q[g].push_back('{cyc, m_rd[g], m_err[g], nb[g], fo[g], foe[g]});
                    phy_write(g);
                end
                prev_mdc[g] = m_mdc[g];
                prev_rv[g]  = m_rv[g];
            end
        end
    end

    task automatic wait_acc(input int g, input int n, input int limit);
        for (int i = 0; i < limit && acc_q[g].size() < n; i++) begin
            @(negedge clk125m); #1;
        end
        check("acc_timeout", acc_q[g].size() >= n, 1);
    endtask

    task automatic wait_rsp(input int g, input int n, input int limit);
        for (int i = 0; i < limit && rsp_q[g].size() < n; i++) begin
            @(negedge clk125m); #1;
        end
        check("rsp_timeout", rsp_q[g].size() >= n, 1);
    endtask

    task automatic verify(input int g, input acc_t a, input rsp_t r, input bit wr,
                          input bit [4:0] pa, input bit [4:0] ra, input bit [15:0] wd);
        int        off = (g == 0) ? 32 : 0;
        bit [63:0] eo = '0;
        bit [63:0] eoe = '0;
        bit [31:0] body;
        bit [15:0] erd;
        bit        eerr;
        check("acc_cmd", {a.wr, a.pa, a.ra, a.wd}, {wr, pa, ra, wd});
        check("latency", r.cyc - a.cyc, (off + 32) * 2 * DH + 1);
        check("nbits", r.nbits, off + 32);
        for (int i = 0; i < off; i++) begin
            eo[i] = 1'b1; eoe[i] = 1'b1;
        end
        body = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra, 2'b10, wd};
        for (int i = 0; i < 32; i++) begin
            eo[off + i]  = body[31 - i];
            eoe[off + i] = wr || (i < 14);
        end
        check("frame_oe", r.foe, eoe);
        check("frame_o", r.fo & eoe, eo & eoe);
        if (wr) begin
            eerr = 1'b0; erd = last_rd[g];
            if (pa <= 2) model_regs[g][pa][ra] = wd;
        end else if (pa <= 2) begin
            eerr = 1'b0; erd = model_regs[g][pa][ra];
        end else begin
            eerr = 1'b1; erd = 16'hFFFF;
        end
        last_rd[g] = erd;
        check("rsp_rdata", r.rd, erd);
        check("rsp_err", r.err, eerr);
    endtask

    task automatic drive(input int g, input bit wr, input bit [4:0] pa, input bit [4:0] ra,
                         input bit [15:0] wd);
        drv_valid[g] = 1'b1; drv_write[g] = wr; drv_phy[g] = pa; drv_reg[g] = ra; drv_wd[g] = wd;
    endtask

    task automatic run_cmd(input int g, input bit wr, input bit [4:0] pa, input bit [4:0] ra,
                           input bit [15:0] wd);
        @(posedge clk125m); #1;
        drive(g, wr, pa, ra, wd);
        wait_acc(g, 1, 200);
        @(posedge clk125m); #1;
        drv_valid[g] = 1'b0;
        wait_rsp(g, 1, 1200);
        if (acc_q[g].size() > 0 && rsp_q[g].size() > 0) begin
            verify(g, acc_q[g].pop_front(), rsp_q[g].pop_front(), wr, pa, ra, wd);
            @(negedge clk125m);
            check("rsp_pulse", m_rv[g], 0);
        end
    endtask

    initial begin
        acc_t a1, a2;
        rsp_t r1, r2;
        drv_valid = '0;
        drv_write = '0;
        for (int g = 0; g < 2; g++) begin
            drv_phy[g] = '0; drv_reg[g] = '0; drv_wd[g] = '0; last_rd[g] = '0;
            for (int p = 0; p < 3; p++)
                for (int r = 0; r < 32; r++) phy_regs[g][p][r] = 16'($urandom);
        end
        phy_regs[0][2][2] = 16'h0141;
        model_regs = phy_regs;

        repeat (3) @(posedge clk125m);
        @(negedge clk125m);
        check("rst_ready", m_ready[0], 0);
        check("rst_rsp_valid", m_rv[0], 0);
        check("rst_rdata", m_rd[0], 0);
        check("rst_err", m_err[0], 0);
        check("rst_mdc", m_mdc[0], 0);
        check("rst_mdio_o", m_o[0], 1);
        check("rst_mdio_oe", m_oe[0], 0);
        @(posedge clk125m); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk125m);
        @(negedge clk125m);
        check("idle_ready", m_ready, 2'b11);
        check("idle_mdc", m_mdc, 2'b00);
        check("idle_oe", m_oe, 2'b00);

        run_cmd(0, 1'b1, 5'd1, 5'd0, 16'h8000);
        run_cmd(0, 1'b0, 5'd2, 5'd2, 16'h0000);
        run_cmd(0, 1'b0, 5'd9, 5'd4, 16'h0000);
        run_cmd(1, 1'b1, 5'd0, 5'd7, 16'h5A3C);
        run_cmd(1, 1'b0, 5'd0, 5'd7, 16'h0000);

        // Back-to-back: cmd_valid stays high, fields change right after the first acceptance.
        @(posedge clk125m); #1;
        drive(0, 1'b1, 5'd2, 5'd17, 16'hC0DE);
        wait_acc(0, 1, 200);
        @(posedge clk125m); #1;
        drive(0, 1'b0, 5'd2, 5'd17, 16'h0000);
        wait_acc(0, 2, 1200);
        @(posedge clk125m); #1;
        drv_valid[0] = 1'b0;
        wait_rsp(0, 2, 1200);
        if (acc_q[0].size() == 2 && rsp_q[0].size() == 2) begin
            a1 = acc_q[0].pop_front(); a2 = acc_q[0].pop_front();
            r1 = rsp_q[0].pop_front(); r2 = rsp_q[0].pop_front();
            verify(0, a1, r1, 1'b1, 5'd2, 5'd17, 16'hC0DE);
            verify(0, a2, r2, 1'b0, 5'd2, 5'd17, 16'h0000);
            check("b2b_accept_cycle", a2.cyc, r1.cyc + 1);
        end

        // Reset in the middle of a read's REGAD field.
        @(posedge clk125m); #1;
        drive(0, 1'b0, 5'd1, 5'd3, 16'h0000);
        wait_acc(0, 1, 200);
        @(posedge clk125m); #1;
        drv_valid[0] = 1'b0;
        for (int i = 0; i < 1000 && nb[0] < 43; i++) @(negedge clk125m);
        check("abort_in_regad", nb[0], 43);
        @(posedge clk125m); #1;
        rst = 1'b1;
        @(posedge clk125m);
        @(negedge clk125m);
        check("abort_mdc", m_mdc[0], 0);
        check("abort_oe", m_oe[0], 0);
        check("abort_rsp_valid", m_rv[0], 0);
        @(posedge clk125m); #1;
        rst = 1'b0;
        repeat (600) @(negedge clk125m);
        check("abort_no_rsp", rsp_q[0].size(), 0);
        acc_q[0].delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        run_cmd(0, 1'b1, 5'd1, 5'd3, 16'hBEEF);
        run_cmd(0, 1'b0, 5'd1, 5'd3, 16'h0000);

        for (int n = 0; n < 10; n++) begin
            run_cmd(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 16'($urandom));
        end

        check("rsp_single_cycle", dbl_rsp, 0);
        check("leftover_events",
              acc_q[0].size() + acc_q[1].size() + rsp_q[0].size() + rsp_q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO management master that sequences the PHY management bus (MDC/MDIO) for phy0..phy2 on the board.
- Accepts single register read/write commands on a valid/ready port and serialises them into MDIO frames on a divided MDC.
- Returns read data and completion on a one-cycle response strobe.
- Top level maps mdio_o/mdio_oe onto the tristate phyN_mdio pad and feeds the pad back into mdio_i.

Parameters:
- DIV_HALF, 25, clk125m cycles per MDC half-period (25 gives 2.5 MHz MDC). Legal minimum is 4.
- PRE_EN, 1, 1 sends a 32-bit all-ones preamble before every frame; 0 suppresses the preamble.

Ports:
- clk125m  input  1  system clock, 125 MHz
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle; command accepted when cmd_valid and cmd_ready are both 1
- cmd_write  input  1  1 = write, 0 = read
- cmd_phyad  input  5  PHY address
- cmd_regad  input  5  register address
- cmd_wdata  input  16  write data
- rsp_valid  output  1  one-cycle completion strobe
- rsp_rdata  output  16  read data, valid with rsp_valid
- rsp_err  output  1  read turnaround error (PHY did not drive 0)
- mdc  output  1  management clock
- mdio_o  output  1  MDIO output data
- mdio_oe  output  1  MDIO output enable (1 = drive)
- mdio_i  input  1  MDIO pad input (asynchronous)

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_o=1, mdio_oe=0. cmd_ready rises in the first cycle after rst deasserts.
- rst asserted mid-frame aborts the frame at once: outputs return to reset values and no rsp_valid is issued.
- mdio_i passes through a 2-flop synchroniser (mdio_s) before use.
- On acceptance, command fields are latched; cmd_ready drops in the next cycle.
- cmd_valid while busy is ignored; the command is neither accepted nor queued.
- States: IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE.
- Bit timing:
  - Each bit is 2*DIV_HALF cycles: MDC low for DIV_HALF cycles, then high for DIV_HALF cycles.
  - A divider counter reloads at every half-period boundary.
  - mdio_o/mdio_oe update in the same cycle mdc goes 1->0, i.e. at the start of the low phase.
  - The first bit starts in the cycle after acceptance, with mdc=0.
- Input sampling: mdio_s is sampled in the cycle mdc goes 0->1.
- Frame, MSB first on every field:
  - PRE: 32 x '1', only if PRE_EN=1.
  - ST: '01'.
  - OP: '10' for read, '01' for write.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA, write: drive '10'.
  - TA, read: mdio_oe=0 for both TA bits. The second TA bit is sampled; if 1, rsp_err=1.
  - DATA, write: drive cmd_wdata.
  - DATA, read: mdio_oe=0; 16 samples shift into rsp_rdata.
- mdio_oe=1 from the start of PRE (or ST) through the end of the write DATA phase, and through REGAD on reads.
- DONE:
  - Entered when the last bit's high phase ends.
  - mdc=0, mdio_oe=0, mdio_o=1.
  - rsp_valid=1 for exactly one cycle.
  - rsp_err is 0 for writes.
  - rsp_rdata holds its previous value on writes.
  - rsp_rdata/rsp_err stay stable until the next read's DONE.
- Return to IDLE the cycle after DONE; cmd_ready=1 one cycle after rsp_valid. A command presented then is accepted immediately.
- Latency, acceptance to rsp_valid: (64 if PRE_EN else 32)*2*DIV_HALF + 1 cycles.
- While idle: mdc=0, mdio_oe=0.

Test Plan:
- Write phyad=1, regad=0, wdata=0x8000, DIV_HALF=4: bus monitor captures 32 ones, then 0101 00001 00000 10 1000000000000000. mdio_oe=1 for all 64 bits. rsp_valid at cycle 513 after acceptance; rsp_err=0.
- Read phyad=2, regad=2 against a bench PHY model that drives TA second bit '0' and data 0x0141: rsp_rdata=0x0141, rsp_err=0. mdio_oe=0 during TA and DATA. OP field observed as '10'.
- Read with no PHY (bench pull-up, mdio_i=1): rsp_err=1, rsp_rdata=0xFFFF, rsp_valid still single-cycle.
- PRE_EN=0, DIV_HALF=4, write: frame begins directly with '01'. rsp_valid at cycle 257.
- cmd_valid held high with two different commands presented back-to-back: only the first is accepted while busy. The second is accepted the cycle cmd_ready returns, and the bench sees two complete, non-overlapping frames.
- rst pulsed during REGAD of a read: same cycle after reset, mdc=0, mdio_oe=0, no rsp_valid. A following write completes normally.
